wb_classic_master: RTL and testbench
====================================

Name: wb_classic_master

Overview:
- Wishbone B4 classic-cycle initiator. It converts a simple valid/ready request port into single READ/WRITE bus cycles.
- Sits between CPU load/store or debug logic and Wishbone responders such as mtimer.
- Handles ack, err and rty terminations, bounded retry, and a no-response timeout.
- Exactly one transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, width of adr_o and req_addr.
- DATA_WIDTH, 32, width of data buses; must be a multiple of 8.
- MAX_RETRIES, 3, number of rty terminations tolerated before the request completes with error.
- TIMEOUT_CYCLES, 256, cycles in BUS state without ack/err/rty before abort; must be ≥2.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_sel  in  DATA_WIDTH/8  byte lanes.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid on a read ack.
- rsp_err  out  1  completion was err, retries exhausted, or timeout.
- rsp_timeout  out  1  completion was a timeout (implies rsp_err).
- cyc_o, stb_o, we_o  out  1  Wishbone control.
- adr_o  out  ADDR_WIDTH  Wishbone address.
- sel_o  out  DATA_WIDTH/8  Wishbone byte select.
- dat_o  out  DATA_WIDTH  Wishbone write data.
- dat_i  in  DATA_WIDTH  Wishbone read data.
- ack_i, err_i, rty_i  in  1  Wishbone terminations.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state = IDLE.
  - All outputs 0 except req_ready = 1.
  - Retry and timeout counters cleared.
  - Reset mid-cycle drops cyc_o/stb_o immediately; no response is issued for the aborted request.
- States: IDLE, BUS, BACKOFF.
- IDLE:
  - req_ready = 1 (combinational on state only).
  - On accept, latch we/addr/sel/wdata into adr_o/we_o/sel_o/dat_o.
  - Assert cyc_o = stb_o = 1 from the next cycle; go to BUS.
  - Clear retry count and timeout count.
- BUS:
  - cyc_o = stb_o = 1; req_ready = 0.
  - Terminations are sampled at each rising edge; priority err_i > ack_i > rty_i.
  - ack_i: drop cyc_o/stb_o, go to IDLE. Pulse rsp_valid next cycle with rsp_err = 0. For a read, rsp_rdata = dat_i sampled on the ack edge.
  - err_i: drop, go to IDLE, pulse rsp_valid with rsp_err = 1, rsp_timeout = 0.
  - rty_i with retry count < MAX_RETRIES: drop cyc_o/stb_o for exactly one cycle (BACKOFF), increment retry count, return to BUS with the same adr/dat/sel/we and the timeout counter reset.
  - rty_i with retry count == MAX_RETRIES: treat as err.
  - No termination: increment the timeout counter. If TIMEOUT_CYCLES edges pass without a termination, drop, go to IDLE, and pulse rsp_valid with rsp_err = rsp_timeout = 1.
- Latency: accept edge N → cyc_o high during N..N+1 → responder ack at edge N+1 → rsp_valid high during cycle N+1..N+2. Minimum 2 cycles from accept to response.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid is high, since the state is already IDLE.
- Bus outputs after completion:
  - adr_o/dat_o/sel_o/we_o hold their last values.
  - rsp_rdata holds until the next read ack.
  - rsp_err/rsp_timeout are 0 whenever rsp_valid is 0.
- Terminations arriving while cyc_o = 0 are ignored.
- No pipelined mode, no block cycles; lock is not supported.

Decomposition:
- Package wb_pkg:
  - State enum (IDLE, BUS, BACKOFF).
  - Response-code constants (OK, BUS_ERR, RETRY_EXHAUSTED, TIMEOUT) for bench reporting.
  - Shared Wishbone width constants.
- Sub-module wb_timeout_counter: saturating down-counter with load/enable and an expired flag. It is reused later by the interconnect watchdog.

Test Plan:
- Write 1000 to mtimer (BASE_ADDRESS 0x100) offset 0 → cyc_o/stb_o high exactly 1 cycle, we_o = 1, sel_o = 4'b1111. rsp_valid pulses 2 cycles after accept, rsp_err = 0.
- Read mtimer offset 0 several cycles after that write → rsp_rdata > 1000, rsp_err = 0. Then write mtimecmp = 1010 at offset 8 and 0 at offset 12; mtimer interrupt asserts within 10 cycles.
- Stub responder asserts rty_i twice, then ack with dat_i = 0xDEADBEEF → stb_o low exactly 1 cycle between attempts, adr_o unchanged, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Stub asserts rty_i 4 times with MAX_RETRIES = 3 → rsp_err = 1, rsp_timeout = 0, 4 bus attempts total.
- Silent responder with TIMEOUT_CYCLES = 16 → cyc_o drops after 16 cycles, rsp_err = rsp_timeout = 1. Next request is accepted in the same cycle as rsp_valid.
- rst_ni pulled low mid-BUS → cyc_o/stb_o low immediately without waiting for a clock, no rsp_valid, req_ready = 1 after release. Simultaneous err_i + ack_i → rsp_err = 1.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone widths, initiator FSM states and completion codes.
package wb_pkg;
    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_DATA_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, BUS, BACKOFF} state_e;
    typedef enum logic [1:0] {OK, BUS_ERR, RETRY_EXHAUSTED, TIMEOUT} rsp_code_e;
endpackage

// File: rtl/wb_classic_master_if.sv
// wb_classic_master_if: Wishbone B4 classic bus between one initiator and one responder.
interface wb_classic_master_if import wb_pkg::*; #(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
);
    logic                    cyc_o;
    logic                    stb_o;
    logic                    we_o;
    logic [ADDR_WIDTH-1:0]   adr_o;
    logic [DATA_WIDTH/8-1:0] sel_o;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic                    ack_i;
    logic                    err_i;
    logic                    rty_i;
    modport master (output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o, input dat_i, ack_i, err_i, rty_i);
    modport slave (input cyc_o, stb_o, we_o, adr_o, sel_o, dat_o, output dat_i, ack_i, err_i, rty_i);
endinterface

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: saturating down-counter; load beats enable, expired while the count is zero.
module wb_timeout_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);
    logic [WIDTH-1:0] r_count;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_count <= '0;
        else if (i_load) r_count <= i_load_val;
        else if (i_en && r_count != '0) r_count <= r_count - 1'b1;
    end
    assign o_expired = (r_count == '0);
endmodule

// File: rtl/wb_classic_master.sv
// wb_classic_master: turns valid/ready requests into single Wishbone classic cycles
// with err/ack/rty handling, bounded retry and a no-response timeout.
module wb_classic_master import wb_pkg::*; #(
    parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int MAX_RETRIES    = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_sel,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    wb_classic_master_if.master     bus
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_e                r_state, w_state;
    logic [RW-1:0]         r_retries;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [SW-1:0]         r_sel;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rsp_valid, r_rsp_err, r_rsp_timeout;
    logic                  w_accept, w_done, w_err, w_timeout, w_rd_capture, w_retry;
    logic                  w_tmo_load, w_tmo_en, w_expired, w_exhausted;

    assign w_exhausted = (r_retries == RW'(MAX_RETRIES));
    assign w_tmo_load  = w_accept || (r_state == BACKOFF);

    // Loaded with TIMEOUT_CYCLES-1 so the abort lands on the TIMEOUT_CYCLES-th silent edge.
    wb_timeout_counter #(.WIDTH(TW)) u_tmo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_load     (w_tmo_load),
        .i_load_val (TW'(TIMEOUT_CYCLES - 1)),
        .i_en       (w_tmo_en),
        .o_expired  (w_expired)
    );

    always_comb begin
        w_state      = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_timeout    = 1'b0;
        w_rd_capture = 1'b0;
        w_retry      = 1'b0;
        w_tmo_en     = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = req_valid;
                w_state  = req_valid ? BUS : IDLE;
            end
            BUS: begin
                if (bus.err_i) begin
                    w_done  = 1'b1;
                    w_err   = 1'b1;
                    w_state = IDLE;
                end else if (bus.ack_i) begin
                    w_done       = 1'b1;
                    w_rd_capture = !r_we;
                    w_state      = IDLE;
                end else if (bus.rty_i) begin
                    w_done  = w_exhausted;
                    w_err   = w_exhausted;
                    w_retry = !w_exhausted;
                    w_state = w_exhausted ? IDLE : BACKOFF;
                end else if (w_expired) begin
                    w_done    = 1'b1;
                    w_err     = 1'b1;
                    w_timeout = 1'b1;
                    w_state   = IDLE;
                end else begin
                    w_tmo_en = 1'b1;
                end
            end
            BACKOFF: w_state = BUS;
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_retries     <= '0;
            r_we          <= 1'b0;
            r_adr         <= '0;
            r_sel         <= '0;
            r_dat         <= '0;
            r_rdata       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_rsp_valid   <= w_done;
            r_rsp_err     <= w_done && w_err;
            r_rsp_timeout <= w_done && w_timeout;
            r_retries     <= w_accept ? '0 : (w_retry ? r_retries + 1'b1 : r_retries);
            if (w_accept) begin
                r_we  <= req_we;
                r_adr <= req_addr;
                r_sel <= req_sel;
                r_dat <= req_wdata;
            end
            if (w_rd_capture) r_rdata <= bus.dat_i;
        end
    end

    // Bus strobes decode from state alone so an async reset drops them at once.
    assign req_ready   = (r_state == IDLE);
    assign bus.cyc_o   = (r_state == BUS);
    assign bus.stb_o   = (r_state == BUS);
    assign bus.we_o    = r_we;
    assign bus.adr_o   = r_adr;
    assign bus.sel_o   = r_sel;
    assign bus.dat_o   = r_dat;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_wb_classic_master.sv
// tb_wb_classic_master: scripted Wishbone responder plus a queue scoreboard fed by a
// transaction-level model of each request's outcome, latency and attempt count.
module tb_wb_classic_master;
    import wb_pkg::*;

    localparam int MAXR = 3;
    localparam int TMO  = 16;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          rtys;
        int          kind;
        int          dly;
    } scr_t;

    typedef struct {
        rsp_code_e   code;
        logic        chk_rd;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_sel;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    bit          in_reset = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc_n = 0;

    scr_t        scr_q[$];
    exp_t        exp_q[$];
    int          acc_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] bus_mem[logic [31:0]];

    wb_classic_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wb_classic_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_RETRIES(MAXR), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_sel(req_sel), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, act, expv, $time);
        end
    endtask

    task automatic flag_fail(input string n);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", n, $time);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
    endfunction

    function automatic int exp_attempts(input scr_t s);
        return (s.rtys <= MAXR) ? s.rtys + 1 : MAXR + 1;
    endfunction

    function automatic int exp_last_len(input scr_t s);
        return (s.kind == 2 && s.rtys <= MAXR) ? TMO : s.dly + 1;
    endfunction

    // kind: 0 ack, 1 err, 2 silent, 3 err+ack together
    task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                         input int rtys, input int kind, input int dly);
        scr_t sc;
        exp_t e;
        int   n;
        int   natt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_sel   = s;
        req_wdata = d;
        sc = '{we: we, adr: a, sel: s, dat: d, rtys: rtys, kind: kind, dly: dly};
        e.code   = (rtys > MAXR) ? RETRY_EXHAUSTED : (kind == 0) ? OK : (kind == 2) ? TIMEOUT : BUS_ERR;
        e.chk_rd = (e.code == OK) && !we;
        e.rdata  = ref_rd(a);
        natt     = exp_attempts(sc);
        e.lat    = (natt - 1) * (dly + 1) + exp_last_len(sc) + (natt - 1) + 1;
        if (we && e.code == OK) ref_mem[a] = merge(ref_rd(a), d, s);
        scr_q.push_back(sc);
        exp_q.push_back(e);
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) flag_fail("req_accept: request never accepted");
        acc_q.push_back(cyc_n);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Responder: decides terminations at negedge for the DUT to sample at the next posedge.
    scr_t cur;
    bit   active = 1'b0, bo_pend = 1'b0, new_att = 1'b0;
    int   atts, len, ridx, wcnt;
    always @(negedge clk) begin
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        bus.rty_i = 1'b0;
        bus.dat_i = $urandom;
        if (in_reset) begin
            active  = 1'b0;
            bo_pend = 1'b0;
            new_att = 1'b0;
        end else if (bus.cyc_o) begin
            if (!active) begin
                if (scr_q.size() == 0) flag_fail("bus_cycle: cyc_o high with no request outstanding");
                else begin
                    cur    = scr_q.pop_front();
                    active = 1'b1;
                    atts   = 1;
                    len    = 0;
                    ridx   = 0;
                    wcnt   = cur.dly;
                end
            end else if (new_att) begin
                new_att = 1'b0;
                atts++;
                len  = 0;
                wcnt = cur.dly;
            end else if (bo_pend) begin
                flag_fail("backoff: cyc_o stayed high after rty");
                bo_pend = 1'b0;
            end
            if (active) begin
                len++;
                chk("stb_o", {31'd0, bus.stb_o}, 32'd1);
                chk("adr_o", bus.adr_o, cur.adr);
                chk("we_o", {31'd0, bus.we_o}, {31'd0, cur.we});
                chk("sel_o", {28'd0, bus.sel_o}, {28'd0, cur.sel});
                if (cur.we) chk("dat_o", bus.dat_o, cur.dat);
                if (wcnt > 0) wcnt--;
                else if (ridx < cur.rtys) begin
                    bus.rty_i = 1'b1;
                    ridx++;
                    bo_pend = (ridx <= MAXR);
                end else begin
                    bus.ack_i = (cur.kind == 0 || cur.kind == 3);
                    bus.err_i = (cur.kind == 1 || cur.kind == 3);
                    if (cur.kind == 0 && cur.we) bus_mem[cur.adr] = merge(bus_rd(cur.adr), cur.dat, cur.sel);
                    if (cur.kind == 0 && !cur.we) bus.dat_i = bus_rd(cur.adr);
                end
            end
        end else begin
            if (bo_pend) begin
                bo_pend = 1'b0;
                new_att = 1'b1;
            end else if (active) begin
                active  = 1'b0;
                new_att = 1'b0;
                chk("attempts", atts, exp_attempts(cur));
                chk("last_attempt_len", len, exp_last_len(cur));
            end
            // stray terminations while the bus is idle must be ignored
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: bus.ack_i = 1'b1;
                    1: bus.err_i = 1'b1;
                    default: bus.rty_i = 1'b1;
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard whenever a completion pulse is seen.
    always @(negedge clk) begin
        exp_t e;
        int   ac;
        if (rsp_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) flag_fail("rsp_unexpected: rsp_valid with nothing outstanding");
            else begin
                e  = exp_q.pop_front();
                ac = acc_q.pop_front();
                chk($sformatf("rsp_err[%s]", e.code.name()), {31'd0, rsp_err}, {31'd0, e.code != OK});
                chk($sformatf("rsp_timeout[%s]", e.code.name()), {31'd0, rsp_timeout}, {31'd0, e.code == TIMEOUT});
                chk($sformatf("latency[%s]", e.code.name()), cyc_n - ac, e.lat);
                chk("req_ready_during_rsp", {31'd0, req_ready}, 32'd1);
                if (e.chk_rd) chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end else begin
            chk("rsp_flags_idle", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_ni    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_sel   = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_cyc_o", {31'd0, bus.cyc_o}, 32'd0);
        chk("reset_stb_o", {31'd0, bus.stb_o}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_adr_o", bus.adr_o, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        rst_ni   = 1'b1;
        in_reset = 1'b0;

        issue(1'b1, 32'h100, 4'hF, 32'd1000, 0, 0, 0);
        issue(1'b0, 32'h100, 4'hF, 32'd0, 0, 0, 2);
        issue(1'b1, 32'h140, 4'hF, 32'hDEADBEEF, 0, 0, 0);
        issue(1'b0, 32'h140, 4'hF, 32'd0, 2, 0, 0);
        issue(1'b0, 32'h104, 4'hF, 32'd0, 4, 0, 0);
        issue(1'b1, 32'h108, 4'h3, 32'h1234_5678, 0, 2, 0);
        issue(1'b0, 32'h108, 4'hF, 32'd0, 0, 0, 0);
        issue(1'b0, 32'h10C, 4'hF, 32'd0, 0, 3, 1);
        issue(1'b1, 32'h110, 4'b0101, 32'hCAFE_F00D, 1, 0, 1);
        issue(1'b0, 32'h110, 4'hF, 32'd0, 3, 0, 0);

        for (int i = 0; i < 200; i++) begin
            int r;
            int rt;
            r  = $urandom_range(0, 9);
            rt = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 4);
            issue($urandom_range(0, 1) == 1, 32'h100 + ($urandom_range(0, 7) << 2), 4'($urandom_range(1, 15)),
                  $urandom, rt, (r <= 5 || r == 9) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a silent bus cycle: strobes fall without a clock edge, no response.
        issue(1'b0, 32'h180, 4'hF, 32'd0, 0, 2, 0);
        @(negedge clk);
        #1;
        rst_ni   = 1'b0;
        in_reset = 1'b1;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        #1;
        chk("midbus_reset_cyc_o", {31'd0, bus.cyc_o}, 32'd0);
        chk("midbus_reset_stb_o", {31'd0, bus.stb_o}, 32'd0);
        chk("midbus_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_ni   = 1'b1;
        in_reset = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_reset_cyc_o", {31'd0, bus.cyc_o}, 32'd0);
        issue(1'b0, 32'h140, 4'hF, 32'd0, 0, 0, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) flag_fail("drain: responses still outstanding");
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
